// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
// The controller uses the master view and the counter uses the slave view.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             SCLR;
  logic             CE;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] MOD;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;
  logic             SAT;

  modport master (
    output SCLR, CE, UP, LOAD, D, MOD,
    input  Q, TC, OVF, SAT
  );

  modport slave (
    input  SCLR, CE, UP, LOAD, D, MOD,
    output Q, TC, OVF, SAT
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with a runtime modulus, a load input and a clear input.
// It wraps or saturates at the count boundary and drives a terminal count for cascading.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  C,
  input  logic                  CLR,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   FULL    = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] q, qNext;
  logic             ovf, ovfNext;
  logic             sat, satNext;
  logic [WIDTH:0]   top;
  logic [WIDTH:0]   qExt;
  logic             atOrAboveTop;
  logic             aboveTop;
  logic             atZero;

  // TOP is kept one bit wider so that MOD=0 can stand for the full 2^WIDTH range.
  assign top          = (bus.MOD == '0) ? FULL : ({1'b0, bus.MOD} - ONE_EXT);
  assign qExt         = {1'b0, q};
  assign atOrAboveTop = (qExt >= top);
  assign aboveTop     = (qExt > top);
  assign atZero       = (q == '0);

  assign bus.TC  = bus.CE & (bus.UP ? atOrAboveTop : atZero);
  assign bus.Q   = q;
  assign bus.OVF = ovf;
  assign bus.SAT = sat;

  always_comb begin
    qNext   = q;
    ovfNext = 1'b0;
    satNext = sat;
    if (bus.SCLR) begin
      qNext   = '0;
      satNext = 1'b0;
    end else if (bus.LOAD) begin
      qNext = ({1'b0, bus.D} > top) ? top[WIDTH-1:0] : bus.D;
    end else if (bus.CE) begin
      if (bus.UP) begin
        if (atOrAboveTop) begin
          qNext   = SATURATE ? top[WIDTH-1:0] : '0;
          ovfNext = 1'b1;
          satNext = 1'b1;
        end else begin
          qNext = q + ONE;
        end
      end else begin
        // A lowered MOD can leave Q above TOP; pull it back without flagging a boundary.
        if (aboveTop) begin
          qNext = top[WIDTH-1:0];
        end else if (atZero) begin
          qNext   = SATURATE ? '0 : top[WIDTH-1:0];
          ovfNext = 1'b1;
          satNext = 1'b1;
        end else begin
          qNext = q - ONE;
        end
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      q   <= '0;
      ovf <= 1'b0;
      sat <= 1'b0;
    end else begin
      q   <= qNext;
      ovf <= ovfNext;
      sat <= satNext;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter.
// It covers wrap, saturate, load priority, modulus change, async reset and a two-stage cascade.
module tb_mod_updown_counter;

  logic C;
  logic CLR;
  int   testsRun;
  int   testsFailed;

  mod_updown_counter_if #(.WIDTH(4)) busW ();
  mod_updown_counter_if #(.WIDTH(4)) busS ();
  mod_updown_counter_if #(.WIDTH(4)) busLo ();
  mod_updown_counter_if #(.WIDTH(4)) busHi ();

  mod_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dutWrap (.C(C), .CLR(CLR), .bus(busW));
  mod_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dutSat  (.C(C), .CLR(CLR), .bus(busS));
  mod_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dutLo   (.C(C), .CLR(CLR), .bus(busLo));
  mod_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dutHi   (.C(C), .CLR(CLR), .bus(busHi));

  // The high digit advances only when the low digit reaches its terminal count.
  assign busHi.CE = busLo.TC;

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sclr, input logic load, input logic ce, input logic up,
                               input logic [3:0] d, input logic [3:0] md);
    busW.SCLR = sclr;
    busW.LOAD = load;
    busW.CE   = ce;
    busW.UP   = up;
    busW.D    = d;
    busW.MOD  = md;
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    CLR = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd10);
    busS.SCLR  = 1'b0; busS.LOAD  = 1'b0; busS.CE  = 1'b0; busS.UP  = 1'b1; busS.D  = '0; busS.MOD  = 4'd6;
    busLo.SCLR = 1'b0; busLo.LOAD = 1'b0; busLo.CE = 1'b0; busLo.UP = 1'b1; busLo.D = '0; busLo.MOD = 4'd10;
    busHi.SCLR = 1'b0; busHi.LOAD = 1'b0;                  busHi.UP = 1'b1; busHi.D = '0; busHi.MOD = 4'd10;

    // Reset state, including TC = CE & ~UP while held in reset.
    repeat (2) @(posedge C);
    #1;
    checkOutput("reset Q", busW.Q, 0);
    checkOutput("reset OVF", busW.OVF, 0);
    checkOutput("reset SAT", busW.SAT, 0);
    checkOutput("reset TC down", busW.TC, 1);
    CLR = 1'b0;

    // Wrap up through MOD=10.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd10);
    for (int k = 0; k < 12; k++) begin
      #1;
      checkOutput($sformatf("wrapup Q k=%0d", k), busW.Q, k % 10);
      checkOutput($sformatf("wrapup TC k=%0d", k), busW.TC, (k % 10) == 9);
      checkOutput($sformatf("wrapup OVF k=%0d", k), busW.OVF, k == 10);
      checkOutput($sformatf("wrapup SAT k=%0d", k), busW.SAT, k >= 10);
      tick();
    end

    // Full-range down count from zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    tick();
    checkOutput("sclr Q", busW.Q, 0);
    checkOutput("sclr SAT", busW.SAT, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    #1;
    checkOutput("wrapdown TC initial", busW.TC, 1);
    tick();
    checkOutput("wrapdown Q 15", busW.Q, 15);
    checkOutput("wrapdown OVF", busW.OVF, 1);
    checkOutput("wrapdown SAT", busW.SAT, 1);
    checkOutput("wrapdown TC after", busW.TC, 0);
    tick();
    checkOutput("wrapdown Q 14", busW.Q, 14);
    checkOutput("wrapdown OVF off", busW.OVF, 0);
    tick();
    checkOutput("wrapdown Q 13", busW.Q, 13);

    // Load priority and clamping.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd10);
    tick();
    checkOutput("load Q 7", busW.Q, 7);
    checkOutput("load OVF", busW.OVF, 0);
    checkOutput("load SAT kept", busW.SAT, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 4'd10);
    tick();
    checkOutput("load clamp Q", busW.Q, 9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd10);
    tick();
    checkOutput("sclr+load Q", busW.Q, 0);
    checkOutput("sclr+load SAT", busW.SAT, 0);

    // Modulus lowered below the current count.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd10);
    tick();
    checkOutput("modchg load Q", busW.Q, 8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5);
    #1;
    checkOutput("modchg up TC", busW.TC, 1);
    tick();
    checkOutput("modchg up Q", busW.Q, 0);
    checkOutput("modchg up OVF", busW.OVF, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd10);
    tick();
    checkOutput("modchg reload Q", busW.Q, 8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5);
    #1;
    checkOutput("modchg down TC", busW.TC, 0);
    tick();
    checkOutput("modchg down Q", busW.Q, 4);
    checkOutput("modchg down OVF", busW.OVF, 0);

    // Asynchronous reset in the middle of a count.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd10);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd10);
    tick();
    repeat (6) tick();
    checkOutput("prereset Q", busW.Q, 6);
    checkOutput("prereset SAT", busW.SAT, 1);
    #2;
    CLR = 1'b1;
    #1;
    checkOutput("async Q", busW.Q, 0);
    checkOutput("async OVF", busW.OVF, 0);
    checkOutput("async SAT", busW.SAT, 0);
    @(posedge C);
    #1;
    CLR = 1'b0;
    checkOutput("restart Q0", busW.Q, 0);
    tick();
    checkOutput("restart Q1", busW.Q, 1);
    checkOutput("restart OVF", busW.OVF, 0);
    tick();
    checkOutput("restart Q2", busW.Q, 2);

    // With a modulus of one, every enabled step is a boundary.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1);
    tick();
    checkOutput("m1 Q a", busW.Q, 0);
    checkOutput("m1 OVF a", busW.OVF, 1);
    checkOutput("m1 TC", busW.TC, 1);
    tick();
    checkOutput("m1 Q b", busW.Q, 0);
    checkOutput("m1 OVF b", busW.OVF, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd10);

    // Saturating instance.
    busS.CE = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checkOutput($sformatf("sat Q j=%0d", j), busS.Q, (j < 5) ? j : 5);
      checkOutput($sformatf("sat OVF j=%0d", j), busS.OVF, j >= 6);
    end
    checkOutput("sat SAT", busS.SAT, 1);
    busS.UP = 1'b0;
    tick();
    checkOutput("sat down Q 4", busS.Q, 4);
    checkOutput("sat down OVF", busS.OVF, 0);
    checkOutput("sat down SAT", busS.SAT, 1);
    tick();
    checkOutput("sat down Q 3", busS.Q, 3);
    busS.CE = 1'b0;

    // Two-digit decimal cascade.
    busLo.SCLR = 1'b1;
    busHi.SCLR = 1'b1;
    tick();
    busLo.SCLR = 1'b0;
    busHi.SCLR = 1'b0;
    busLo.CE   = 1'b1;
    for (int n = 0; n <= 100; n++) begin
      #1;
      checkOutput($sformatf("cascade n=%0d", n), busHi.Q * 10 + busLo.Q, n % 100);
      if (n == 99) checkOutput("cascade hi TC", busHi.TC, 1);
      if (n == 100) checkOutput("cascade hi OVF", busHi.OVF, 1);
      tick();
    end
    busLo.CE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised modulo counter with runtime-programmable modulus, up/down direction, count enable, synchronous load and clear, and wrap or saturate boundary mode. It is the general-purpose counter primitive for the counters library, used standalone or cascaded through its terminal-count output to build wider counters.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at boundary

Ports:
- C  in  1  clock; all state updates on rising edge
- CLR  in  1  reset CLR, asynchronous, active-high; forces Q=0, OVF=0, SAT=0
- SCLR  in  1  synchronous clear, active-high
- CE  in  1  count enable
- UP  in  1  direction: 1 = up, 0 = down
- LOAD  in  1  synchronous load of D
- D  in  WIDTH  load value
- MOD  in  WIDTH  modulus M; MOD=0 means M = 2^WIDTH
- Q  out  WIDTH  count value, registered
- TC  out  1  terminal count, combinational, for cascading
- OVF  out  1  one-cycle pulse, registered, on a boundary event
- SAT  out  1  sticky boundary flag, registered

## Operation
- Legal count range: 0..M-1. Define TOP = M-1, computed in WIDTH+1 bits. MOD=0 gives TOP = 2^WIDTH-1.
- Per-edge priority is CLR (async) > SCLR > LOAD > CE. When none is active, Q holds.
- SCLR: Q=0, OVF=0, SAT=0.
- LOAD: Q = min(D, TOP). OVF=0. SAT is unchanged. CE is ignored in that cycle.
- CE with UP=1:
  - If Q < TOP: Q+1.
  - If Q ≥ TOP: this is a boundary event. Wrap mode sets Q=0. Saturate mode sets Q=TOP.
- CE with UP=0:
  - If Q > TOP: Q=TOP. This is not a boundary event. It covers MOD being lowered below the current Q.
  - If 0 < Q ≤ TOP: Q-1.
  - If Q = 0: this is a boundary event. Wrap mode sets Q=TOP. Saturate mode holds Q=0.
- Boundary event: OVF=1 for exactly the next cycle, and SAT=1 until SCLR or CLR. OVF is 0 on every other edge.
- TC = CE & (UP ? (Q ≥ TOP) : (Q == 0)). TC is high in the same cycle that the boundary event is registered. Wiring TC to the CE of the next stage produces a carry-chained cascade.
- M=1 (MOD=1): TOP=0, so every enabled count is a boundary event and Q stays 0.
- MOD and UP may change on any cycle. They take effect at the next edge. No internal copy of MOD is held.
- Arithmetic is unsigned, with no overflow beyond WIDTH. Q is never greater than TOP after any count step or load.

## Timing
- Q, OVF and SAT are registered and change one C edge after the qualifying inputs are sampled. Latency is 1 cycle.
- TC is combinational from Q, MOD, UP and CE, with zero latency. Downstream logic must register it or use it only as an enable.
- CLR asserts asynchronously and immediately forces Q=0, OVF=0, SAT=0, regardless of C.
- Release of CLR must be synchronous to C. The first count occurs on the first edge after release at which CE=1.
- Reset mid-count: any partially completed boundary event is discarded, and OVF is not asserted after reset.
- Simultaneous SCLR+LOAD+CE: only SCLR takes effect. Simultaneous LOAD+CE: only LOAD takes effect.
- Reset value of every output: Q=0, OVF=0, SAT=0. TC = CE & ~UP while in reset, because Q=0.

## Test plan
- Wrap up: WIDTH=4, MOD=10, UP=1, CE=1 for 12 cycles from reset.
  - Q sequence is 0..9, 0, 1.
  - TC is high while Q=9.
  - OVF pulses once, in the cycle Q=0 after wrapping.
  - SAT=1 thereafter.
- Wrap down and full range: WIDTH=4, MOD=0, UP=0, CE=1 from Q=0.
  - Q goes 15, 14, ….
  - OVF pulses on the first step.
  - TC is high in the initial cycle.
- Saturate: SATURATE=1, WIDTH=4, MOD=6, UP=1, CE=1 for 8 cycles.
  - Q goes 0..5, then holds at 5.
  - OVF pulses once per enabled cycle at 5.
  - SAT=1.
  - Reversing direction with UP=0 counts down 4, 3, ….
- Load and priority, at MOD=10:
  - LOAD D=7 with CE=1 gives Q=7.
  - LOAD D=12 gives Q=9 (clamped).
  - SCLR+LOAD gives Q=0 and SAT=0.
- Modulus change: Q=8, set MOD=5.
  - UP=1 with CE gives Q=0 and an OVF pulse.
  - Repeat from Q=8 with UP=0: Q=4, no OVF.
- Async reset mid-count: assert CLR between edges with Q=6.
  - Q, OVF and SAT are 0 immediately.
  - After release, counting restarts 0, 1, 2.
  - A two-stage cascade (TC→CE), WIDTH=4, MOD=10 each, counts 00..99 and wraps.
